sodor5_wb_scoreboard: RTL and testbench

//  Consumer end of the sodor5 instruction-stream check: takes register-writeback events from the

---
 rtl/sodor5_verif_pkg.sv | 15 +
 rtl/sodor5_wb_fifo.sv | 64 ++++++
 rtl/sodor5_wb_scoreboard.sv | 103 ++++++++++
 tb/tb_sodor5_wb_scoreboard.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sodor5_verif_pkg.sv
// Shared types and sizing for the sodor5 writeback scoreboard.
package sodor5_verif_pkg;

    localparam int unsigned NUM_REGS      = 32;
    localparam int unsigned REG_AW        = $clog2(NUM_REGS);
    localparam int unsigned WORD_SIZE     = 32;
    localparam int unsigned WB_FIFO_DEPTH = 8;

    // One architectural register writeback: destination index and value.
    typedef struct packed {
        logic [REG_AW-1:0]    rd;
        logic [WORD_SIZE-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/sodor5_wb_fifo.sv
// Synchronous FIFO with async reset. Pointers wrap modulo DEPTH; occupancy
// is held in its own counter so full and empty never alias.
module sodor5_wb_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 37
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       drop_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem[rd_q];
    assign count_o = count_q;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign drop_o  = push_i && full_o && !pop_i;

    // Next pointer and occupancy values.
    always_comb begin
        push_ok = push_i && (!full_o || pop_i);
        do_pop  = pop_i && !empty_o;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push_ok) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        if (push_ok && !do_pop)      count_d = count_q + 1'b1;
        else if (!push_ok && do_pop) count_d = count_q - 1'b1;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_q] <= data_i;
    end

endmodule

// File: rtl/sodor5_wb_scoreboard.sv
// Buffers ref/dut register writebacks and compares them in program order,
// capturing the first divergence and keeping saturating counts.
module sodor5_wb_scoreboard #(
    parameter int unsigned DEPTH     = sodor5_verif_pkg::WB_FIFO_DEPTH,
    parameter int unsigned WORD_SIZE = sodor5_verif_pkg::WORD_SIZE,
    parameter int unsigned REG_AW    = sodor5_verif_pkg::REG_AW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ref_wb_valid,
    input  logic [REG_AW-1:0]        ref_wb_rd,
    input  logic [WORD_SIZE-1:0]     ref_wb_data,
    input  logic                     dut_wb_valid,
    input  logic [REG_AW-1:0]        dut_wb_rd,
    input  logic [WORD_SIZE-1:0]     dut_wb_data,
    output logic                     mismatch,
    output logic [REG_AW-1:0]        first_rd_exp,
    output logic [REG_AW-1:0]        first_rd_got,
    output logic [WORD_SIZE-1:0]     first_data_exp,
    output logic [WORD_SIZE-1:0]     first_data_got,
    output logic [31:0]              first_index,
    output logic [31:0]              compare_count,
    output logic [15:0]              error_count,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   ref_pending,
    output logic [$clog2(DEPTH):0]   dut_pending
);
    localparam int unsigned EW = REG_AW + WORD_SIZE;

    logic [EW-1:0] ref_head, dut_head;
    logic          ref_empty, dut_empty, ref_full, dut_full, ref_drop, dut_drop;
    logic          ref_push, dut_push, fire, fail;

    logic                 mismatch_q, overflow_q;
    logic [REG_AW-1:0]    rd_exp_q, rd_got_q;
    logic [WORD_SIZE-1:0] data_exp_q, data_got_q;
    logic [31:0]          index_q, cmp_q;
    logic [15:0]          err_q;

    // x0 writes carry no architectural state and are filtered before queueing.
    assign ref_push = ref_wb_valid && (ref_wb_rd != '0);
    assign dut_push = dut_wb_valid && (dut_wb_rd != '0);

    sodor5_wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_ref_fifo (
        .clk(clk), .reset(reset), .push_i(ref_push), .data_i({ref_wb_rd, ref_wb_data}),
        .pop_i(fire), .data_o(ref_head), .full_o(ref_full), .empty_o(ref_empty),
        .drop_o(ref_drop), .count_o(ref_pending)
    );

    sodor5_wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_dut_fifo (
        .clk(clk), .reset(reset), .push_i(dut_push), .data_i({dut_wb_rd, dut_wb_data}),
        .pop_i(fire), .data_o(dut_head), .full_o(dut_full), .empty_o(dut_empty),
        .drop_o(dut_drop), .count_o(dut_pending)
    );

    // A compare happens whenever both heads hold an entry.
    always_comb begin
        fire = !ref_empty && !dut_empty;
        fail = fire && (ref_head != dut_head);
    end

    // Sticky flags, first-failure capture and saturating counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mismatch_q <= 1'b0;
            overflow_q <= 1'b0;
            rd_exp_q   <= '0;
            rd_got_q   <= '0;
            data_exp_q <= '0;
            data_got_q <= '0;
            index_q    <= '0;
            cmp_q      <= '0;
            err_q      <= '0;
        end else begin
            if (ref_drop || dut_drop) overflow_q <= 1'b1;
            if (fire && (cmp_q != '1)) cmp_q <= cmp_q + 1'b1;
            if (fail && (err_q != '1)) err_q <= err_q + 1'b1;
            if (fail && !mismatch_q) begin
                mismatch_q <= 1'b1;
                rd_exp_q   <= ref_head[EW-1:WORD_SIZE];
                rd_got_q   <= dut_head[EW-1:WORD_SIZE];
                data_exp_q <= ref_head[WORD_SIZE-1:0];
                data_got_q <= dut_head[WORD_SIZE-1:0];
                index_q    <= cmp_q;
            end
        end
    end

    assign mismatch       = mismatch_q;
    assign overflow       = overflow_q;
    assign first_rd_exp   = rd_exp_q;
    assign first_rd_got   = rd_got_q;
    assign first_data_exp = data_exp_q;
    assign first_data_got = data_got_q;
    assign first_index    = index_q;
    assign compare_count  = cmp_q;
    assign error_count    = err_q;

    // Full flags only feed the drop logic inside each FIFO.
    logic unused_full;
    assign unused_full = ref_full ^ dut_full;

endmodule

// File: tb/tb_sodor5_wb_scoreboard.sv
// Directed bench for sodor5_wb_scoreboard with hand-computed expectations.
module tb_sodor5_wb_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        ref_wb_valid, dut_wb_valid;
    logic [4:0]  ref_wb_rd, dut_wb_rd;
    logic [31:0] ref_wb_data, dut_wb_data;
    logic        mismatch, overflow;
    logic [4:0]  first_rd_exp, first_rd_got;
    logic [31:0] first_data_exp, first_data_got, first_index, compare_count;
    logic [15:0] error_count;
    logic [3:0]  ref_pending, dut_pending;

    int n_checks = 0;
    int n_pass   = 0;

    sodor5_wb_scoreboard #(.DEPTH(8), .WORD_SIZE(32), .REG_AW(5)) dut (
        .clk(clk), .reset(reset),
        .ref_wb_valid(ref_wb_valid), .ref_wb_rd(ref_wb_rd), .ref_wb_data(ref_wb_data),
        .dut_wb_valid(dut_wb_valid), .dut_wb_rd(dut_wb_rd), .dut_wb_data(dut_wb_data),
        .mismatch(mismatch), .first_rd_exp(first_rd_exp), .first_rd_got(first_rd_got),
        .first_data_exp(first_data_exp), .first_data_got(first_data_got),
        .first_index(first_index), .compare_count(compare_count),
        .error_count(error_count), .overflow(overflow),
        .ref_pending(ref_pending), .dut_pending(dut_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    // Present inputs for one edge, then sample 1ns after it.
    task automatic tick(input logic rv, input logic [4:0] rrd, input logic [31:0] rdat,
                        input logic dv, input logic [4:0] drd, input logic [31:0] ddat);
        ref_wb_valid = rv; ref_wb_rd = rrd; ref_wb_data = rdat;
        dut_wb_valid = dv; dut_wb_rd = drd; dut_wb_data = ddat;
        @(posedge clk); #1;
        ref_wb_valid = 1'b0; dut_wb_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        ref_wb_valid = 1'b0; ref_wb_rd = '0; ref_wb_data = '0;
        dut_wb_valid = 1'b0; dut_wb_rd = '0; dut_wb_data = '0;
        idle(2);
        chk("rst_mismatch", 32'(mismatch), 32'd0);
        chk("rst_cmp",      compare_count, 32'd0);
        chk("rst_err",      32'(error_count), 32'd0);
        chk("rst_ovf",      32'(overflow), 32'd0);
        chk("rst_refpend",  32'(ref_pending), 32'd0);
        reset = 1'b0;
        idle(1);

        // 1: skewed matching pair.
        tick(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        idle(3);
        chk("t1_refpend_wait", 32'(ref_pending), 32'd1);
        chk("t1_cmp_wait",     compare_count, 32'd0);
        tick(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
        chk("t1_cmp_nobypass", compare_count, 32'd0);
        chk("t1_dutpend",      32'(dut_pending), 32'd1);
        idle(1);
        chk("t1_cmp",      compare_count, 32'd1);
        chk("t1_mismatch", 32'(mismatch), 32'd0);
        chk("t1_refpend",  32'(ref_pending), 32'd0);
        chk("t1_dutpend0", 32'(dut_pending), 32'd0);

        // 2: data mismatch then rd mismatch.
        do_reset();
        tick(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB);
        idle(1);
        chk("t2_mismatch", 32'(mismatch), 32'd1);
        chk("t2_dexp",     first_data_exp, 32'hA);
        chk("t2_dgot",     first_data_got, 32'hB);
        chk("t2_rdexp",    32'(first_rd_exp), 32'd3);
        chk("t2_rdgot",    32'(first_rd_got), 32'd3);
        chk("t2_index",    first_index, 32'd0);
        chk("t2_err1",     32'(error_count), 32'd1);
        tick(1'b1, 5'd4, 32'd1, 1'b1, 5'd9, 32'd1);
        idle(1);
        chk("t2_err2",     32'(error_count), 32'd2);
        chk("t2_cmp2",     compare_count, 32'd2);
        chk("t2_rdgot_keep", 32'(first_rd_got), 32'd3);
        chk("t2_dgot_keep",  first_data_got, 32'hB);
        chk("t2_index_keep", first_index, 32'd0);

        // 3: x0 writes are filtered.
        do_reset();
        tick(1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd6);
        idle(1);
        chk("t3_cmp",     compare_count, 32'd0);
        chk("t3_refpend", 32'(ref_pending), 32'd0);
        chk("t3_dutpend", 32'(dut_pending), 32'd0);
        chk("t3_mismatch", 32'(mismatch), 32'd0);

        // 4: fill ref side, overflow, then drain with matching dut entries.
        do_reset();
        for (int i = 0; i < 8; i++) tick(1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0);
        chk("t4_full_noovf", 32'(overflow), 32'd0);
        chk("t4_refpend8",   32'(ref_pending), 32'd8);
        tick(1'b1, 5'd9, 32'h108, 1'b0, 5'd0, 32'd0);
        chk("t4_ovf",        32'(overflow), 32'd1);
        chk("t4_refpend_sat", 32'(ref_pending), 32'd8);
        chk("t4_cmp0",       compare_count, 32'd0);
        for (int i = 0; i < 8; i++) tick(1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 1), 32'h100 + 32'(i));
        idle(1);
        chk("t4_cmp8",       compare_count, 32'd8);
        chk("t4_err0",       32'(error_count), 32'd0);
        chk("t4_refpend0",   32'(ref_pending), 32'd0);
        chk("t4_ovf_sticky", 32'(overflow), 32'd1);

        // 5: back-to-back matching stream.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 5'((i % 31) + 1), 32'(i * 3 + 7), 1'b1, 5'((i % 31) + 1), 32'(i * 3 + 7));
            if (i == 10) begin
                chk("t5_cmp_mid",     compare_count, 32'd10);
                chk("t5_refpend_mid", 32'(ref_pending), 32'd1);
                chk("t5_dutpend_mid", 32'(dut_pending), 32'd1);
            end
        end
        chk("t5_cmp_last", compare_count, 32'd19);
        idle(1);
        chk("t5_cmp20",    compare_count, 32'd20);
        chk("t5_err0",     32'(error_count), 32'd0);
        idle(1);
        chk("t5_cmp_hold", compare_count, 32'd20);
        chk("t5_refpend0", 32'(ref_pending), 32'd0);

        // 6: asynchronous reset mid-stream.
        do_reset();
        tick(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB);
        idle(1);
        for (int i = 0; i < 3; i++) tick(1'b1, 5'(i + 10), 32'(i), 1'b0, 5'd0, 32'd0);
        chk("t6_pre_mismatch", 32'(mismatch), 32'd1);
        chk("t6_pre_refpend",  32'(ref_pending), 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("t6_mismatch", 32'(mismatch), 32'd0);
        chk("t6_cmp",      compare_count, 32'd0);
        chk("t6_err",      32'(error_count), 32'd0);
        chk("t6_refpend",  32'(ref_pending), 32'd0);
        chk("t6_dexp",     first_data_exp, 32'd0);
        chk("t6_dgot",     first_data_got, 32'd0);
        reset = 1'b0;
        tick(1'b1, 5'd7, 32'h55, 1'b1, 5'd7, 32'h55);
        idle(1);
        chk("t6_post_cmp",      compare_count, 32'd1);
        chk("t6_post_mismatch", 32'(mismatch), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
